// File: rtl/conv_scan_ctrl_if.sv
// rtl/conv_scan_ctrl_if.sv - layer-FSM / scan-sequencer handshake bundle
// Optional stride2 signal present only when CONV_SCAN_STRIDE2_EN is defined.
interface conv_scan_ctrl_if #(
    parameter int SIZE_W = 5,
    parameter int ADDR_W = 10
);
    logic              start;
    logic [SIZE_W-1:0] matrix;
    logic              stall;
`ifdef CONV_SCAN_STRIDE2_EN
    logic              stride2;
`endif
    logic              busy;
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        prov;
    logic [1:0]        vprov;
    logic              done;

    modport master (
`ifdef CONV_SCAN_STRIDE2_EN
        output stride2,
`endif
        output start,
        output matrix,
        output stall,
        input  busy,
        input  valid,
        input  addr,
        input  prov,
        input  vprov,
        input  done
    );

    modport slave (
`ifdef CONV_SCAN_STRIDE2_EN
        input  stride2,
`endif
        input  start,
        input  matrix,
        input  stall,
        output busy,
        output valid,
        output addr,
        output prov,
        output vprov,
        output done
    );
endinterface

// File: rtl/conv_scan_ctrl.sv
// rtl/conv_scan_ctrl.sv - raster-order pixel scan sequencer with border codes
// Optional 2x stride (max-pool) enabled by defining CONV_SCAN_STRIDE2_EN.
module conv_scan_ctrl #(
    parameter int SIZE_W = 5,
    parameter int ADDR_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    conv_scan_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [SIZE_W-1:0] msize_q, msize_d;
    logic [SIZE_W-1:0] col_q, col_d;
    logic [SIZE_W-1:0] row_q, row_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        prov_q, prov_d;
    logic [1:0]        vprov_q, vprov_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [SIZE_W-1:0] step;
    logic [ADDR_W-1:0] row_inc;
    logic [SIZE_W:0]   col_sum;
    logic [SIZE_W:0]   row_sum;
    logic              col_wrap;
    logic              row_wrap;

`ifdef CONV_SCAN_STRIDE2_EN
    logic stride2_q, stride2_d;

    assign step    = stride2_q ? SIZE_W'(2) : SIZE_W'(1);
    assign row_inc = stride2_q ? ADDR_W'({msize_q, 1'b0}) : ADDR_W'(msize_q);
`else
    assign step    = SIZE_W'(1);
    assign row_inc = ADDR_W'(msize_q);
`endif

    // One extra bit so col+step / row+step never wrap before the compare.
    assign col_sum  = {1'b0, col_q} + {1'b0, step};
    assign row_sum  = {1'b0, row_q} + {1'b0, step};
    assign col_wrap = (col_sum >= {1'b0, msize_q});
    assign row_wrap = (row_sum >= {1'b0, msize_q});

    function automatic logic [1:0] border_code(input logic [SIZE_W-1:0] pos,
                                               input logic [SIZE_W-1:0] size);
        if (pos == '0) begin
            return 2'b11;
        end else if (pos == size - SIZE_W'(1)) begin
            return 2'b10;
        end else begin
            return 2'b00;
        end
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            msize_q    <= '0;
            col_q      <= '0;
            row_q      <= '0;
            row_base_q <= '0;
            addr_q     <= '0;
            prov_q     <= '0;
            vprov_q    <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef CONV_SCAN_STRIDE2_EN
            stride2_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            msize_q    <= msize_d;
            col_q      <= col_d;
            row_q      <= row_d;
            row_base_q <= row_base_d;
            addr_q     <= addr_d;
            prov_q     <= prov_d;
            vprov_q    <= vprov_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef CONV_SCAN_STRIDE2_EN
            stride2_q  <= stride2_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        msize_d    = msize_q;
        col_d      = col_q;
        row_d      = row_q;
        row_base_d = row_base_q;
        addr_d     = addr_q;
        prov_d     = prov_q;
        vprov_d    = vprov_q;
        valid_d    = valid_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
`ifdef CONV_SCAN_STRIDE2_EN
        stride2_d  = stride2_q;
`endif

        case (state_q)
            S_IDLE: begin
                valid_d = 1'b0;
                busy_d  = 1'b0;
                if (bus.start) begin
                    busy_d = 1'b1;
                    if (bus.matrix >= SIZE_W'(2)) begin
                        state_d    = S_SCAN;
                        msize_d    = bus.matrix;
`ifdef CONV_SCAN_STRIDE2_EN
                        stride2_d  = bus.stride2;
`endif
                        col_d      = '0;
                        row_d      = '0;
                        row_base_d = '0;
                        addr_d     = '0;
                        prov_d     = 2'b11;
                        vprov_d    = 2'b11;
                        valid_d    = 1'b1;
                    end else begin
                        // Degenerate map: report completion without any beats.
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end
                end
            end

            S_SCAN: begin
                if (!bus.stall) begin
                    if (col_wrap && row_wrap) begin
                        state_d    = S_DONE;
                        done_d     = 1'b1;
                        valid_d    = 1'b0;
                        col_d      = '0;
                        row_d      = '0;
                        row_base_d = '0;
                        addr_d     = '0;
                        prov_d     = 2'b00;
                        vprov_d    = 2'b00;
                    end else if (col_wrap) begin
                        col_d      = '0;
                        row_d      = row_sum[SIZE_W-1:0];
                        row_base_d = row_base_q + row_inc;
                        addr_d     = row_base_q + row_inc;
                        prov_d     = 2'b11;
                        vprov_d    = border_code(row_sum[SIZE_W-1:0], msize_q);
                    end else begin
                        col_d  = col_sum[SIZE_W-1:0];
                        addr_d = row_base_q + ADDR_W'(col_sum[SIZE_W-1:0]);
                        prov_d = border_code(col_sum[SIZE_W-1:0], msize_q);
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                valid_d = 1'b0;
            end

            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign bus.busy  = busy_q;
    assign bus.valid = valid_q;
    assign bus.addr  = addr_q;
    assign bus.prov  = prov_q;
    assign bus.vprov = vprov_q;
    assign bus.done  = done_q;

endmodule

// File: tb/tb_conv_scan_ctrl.sv
// tb/tb_conv_scan_ctrl.sv - table-driven scoreboard bench for conv_scan_ctrl
module tb_conv_scan_ctrl;

    logic clk;
    logic rst;

    conv_scan_ctrl_if #(.SIZE_W(5), .ADDR_W(10)) bus ();

    conv_scan_ctrl #(.SIZE_W(5), .ADDR_W(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int m;
        int s2;
        int stall_a;
        int stall_b;
        int stall_len;
        int poke;
        int exp_beats;
        int exp_last;
    } vec_t;

    typedef struct packed {
        logic [9:0] addr;
        logic [1:0] prov;
        logic [1:0] vprov;
    } beat_t;

    beat_t exp_q[$];
    vec_t  vecs[$];
    int    checks = 0;
    int    fails  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic build_model(input int m, input int s2);
        int step;
        beat_t b;
        step = (s2 != 0) ? 2 : 1;
        exp_q.delete();
        if (m >= 2) begin
            for (int r = 0; r < m; r += step) begin
                for (int c = 0; c < m; c += step) begin
                    b.addr  = 10'(r * m + c);
                    b.prov  = (c == 0) ? 2'b11 : ((c == m - 1) ? 2'b10 : 2'b00);
                    b.vprov = (r == 0) ? 2'b11 : ((r == m - 1) ? 2'b10 : 2'b00);
                    exp_q.push_back(b);
                end
            end
        end
    endtask

    task automatic run_scan(input vec_t v);
        int    cyc;
        int    beats;
        int    stalls;
        int    scnt;
        int    last;
        int    got_done;
        beat_t front;

        build_model(v.m, v.s2);
        bus.matrix = 5'(v.m);
        bus.stall  = 1'b0;
        bus.start  = 1'b1;
`ifdef CONV_SCAN_STRIDE2_EN
        bus.stride2 = (v.s2 != 0);
`endif
        @(posedge clk); #1;
        bus.start  = 1'b0;
        bus.matrix = 5'($urandom_range(0, 31));
`ifdef CONV_SCAN_STRIDE2_EN
        bus.stride2 = (v.s2 == 0);
`endif
        cyc = 1; beats = 0; stalls = 0; scnt = 0; last = -1; got_done = 0;

        while (cyc < 3000) begin
            if (v.poke >= 0 && beats == v.poke) begin
                bus.start  = 1'b1;
                bus.matrix = 5'd28;
            end else begin
                bus.start = 1'b0;
            end
            bus.stall = 1'b0;
            if (bus.valid && exp_q.size() > 0 && scnt < v.stall_len &&
                (int'(exp_q[0].addr) == v.stall_a || int'(exp_q[0].addr) == v.stall_b)) begin
                bus.stall = 1'b1;
                scnt++;
            end
            if (bus.done) begin
                got_done = 1;
                break;
            end
            if (bus.valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected beat", 0, 1);
                end else begin
                    front = exp_q[0];
                    check("addr", 32'(bus.addr), 32'(front.addr));
                    check("prov", 32'(bus.prov), 32'(front.prov));
                    check("vprov", 32'(bus.vprov), 32'(front.vprov));
                    check("busy in scan", 32'(bus.busy), 1);
                    if (!bus.stall) begin
                        void'(exp_q.pop_front());
                        beats++;
                        last = int'(bus.addr);
                        scnt = 0;
                    end else begin
                        stalls++;
                    end
                end
            end
            @(posedge clk); #1;
            cyc++;
        end

        bus.start = 1'b0;
        bus.stall = 1'b0;
        check("done seen", got_done, 1);
        check("done cycle", cyc, v.exp_beats + stalls + 1);
        check("beat count", beats, v.exp_beats);
        check("model drained", exp_q.size(), 0);
        if (v.exp_beats > 0) check("last addr", last, v.exp_last);
        check("busy with done", 32'(bus.busy), 1);
        check("valid with done", 32'(bus.valid), 0);
        @(posedge clk); #1;
        check("done one cycle", 32'(bus.done), 0);
        check("busy after done", 32'(bus.busy), 0);
        exp_q.delete();
    endtask

    initial begin
        vec_t v;
        int   found;

        //        m  s2 st_a st_b len poke beats last
        vecs.push_back('{4,  0, -1, -1, 0, -1, 16, 15});
        vecs.push_back('{3,  0,  4,  8, 2, -1,  9,  8});
        vecs.push_back('{1,  0, -1, -1, 0, -1,  0,  0});
        vecs.push_back('{0,  0, -1, -1, 0, -1,  0,  0});
        vecs.push_back('{5,  0, -1, -1, 0,  3, 25, 24});
        vecs.push_back('{2,  0,  1, -1, 3, -1,  4,  3});
        vecs.push_back('{31, 0, 100, 960, 2, -1, 961, 960});
`ifdef CONV_SCAN_STRIDE2_EN
        vecs.push_back('{5,  1, 12, -1, 2, -1,  9, 24});
        vecs.push_back('{6,  1, -1, -1, 0, -1,  9, 28});
        vecs.push_back('{2,  1, -1, -1, 0, -1,  1,  0});
`endif

        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.matrix = '0;
        bus.stall  = 1'b0;
`ifdef CONV_SCAN_STRIDE2_EN
        bus.stride2 = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("reset outputs", 32'({bus.busy, bus.valid, bus.done, bus.addr, bus.prov, bus.vprov}), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < vecs.size(); i++) begin
            run_scan(vecs[i]);
            @(posedge clk); #1;
        end

        // Asynchronous reset mid-scan, then a clean restart.
        bus.matrix = 5'd4;
        bus.start  = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        found = 0;
        for (int k = 0; k < 20; k++) begin
            if (bus.valid && bus.addr == 10'd7) begin
                found = 1;
                break;
            end
            @(posedge clk); #1;
        end
        check("reached addr 7", found, 1);
        #2 rst = 1'b1;
        #1;
        check("async reset outputs", 32'({bus.busy, bus.valid, bus.done, bus.addr, bus.prov, bus.vprov}), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        v = '{4, 0, -1, -1, 0, -1, 16, 15};
        run_scan(v);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
